// File: rtl/gf180mcu_osu_sc_gp12t3v3__clkbuf_div_if.sv
// Control/status bundle for the gateable clock-divider buffer.
// The master side issues the run request and ratio; the slave side is the
// divider, which returns the divided clock and its status flags.
interface gf180mcu_osu_sc_gp12t3v3__clkbuf_div_if #(
  parameter int WIDTH = 4
);
  logic             EN;   // run request, may be asynchronous to CLK
  logic [WIDTH-1:0] DIV;  // half-period minus one, in CLK cycles
  logic             Y;    // divided clock
  logic             RUN;  // divider is running
  logic             ACK;  // one-cycle pulse at each period start that loaded DIV

  modport master (
    output EN,
    output DIV,
    input  Y,
    input  RUN,
    input  ACK
  );

  modport slave (
    input  EN,
    input  DIV,
    output Y,
    output RUN,
    output ACK
  );
endinterface

// File: rtl/gf180mcu_osu_sc_gp12t3v3__clkbuf_div.sv
// Gateable 50%-duty clock divider for the 12-track 3.3 V library.
// Y has a high phase and a low phase of (d_act+1) CLK cycles each. The ratio
// is reloaded, and a stop request honoured, only at a period boundary (the
// end of a low phase), so Y never carries a truncated pulse. All outputs come
// straight from flops.
module gf180mcu_osu_sc_gp12t3v3__clkbuf_div #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2   // legal range 1..4
) (
  input  logic                                         CLK,
  input  logic                                         RN,
  gf180mcu_osu_sc_gp12t3v3__clkbuf_div_if.slave        bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   en_s;

  state_t                 state;
  logic [WIDTH-1:0]       cnt;
  logic [WIDTH-1:0]       d_act;
  logic                   y_q;
  logic                   run_q;
  logic                   ack_q;

  // Bring the asynchronous run request into the CLK domain.
  // NOTE: the synchroniser flops are reset too, so a request left high across
  // reset is re-captured from scratch and restart latency stays deterministic.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= bus.EN;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign en_s = sync_q[SYNC_STAGES-1];

  // Divider state machine; Y, RUN and ACK are registered here alongside state.
  // NOTE: every assignment in this clocked block is non-blocking, so all
  // decisions use the values from before the edge regardless of statement order.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state <= ST_IDLE;
      cnt   <= '0;
      d_act <= '0;
      y_q   <= 1'b0;
      run_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      // ACK is a single-cycle pulse; only a ratio load raises it again.
      ack_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (en_s) begin
            d_act <= bus.DIV;
            cnt   <= '0;
            y_q   <= 1'b1;
            ack_q <= 1'b1;
            run_q <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (cnt != d_act) begin
            // Mid-phase: count; cnt never passes d_act, so no wrap exists.
            cnt <= cnt + 1'b1;
          end else if (y_q) begin
            // End of high phase: enter low phase unconditionally.
            cnt <= '0;
            y_q <= 1'b0;
          end else if (en_s) begin
            // Period boundary with run still requested: reload the ratio.
            d_act <= bus.DIV;
            cnt   <= '0;
            y_q   <= 1'b1;
            ack_q <= 1'b1;
          end else begin
            // Period boundary with run withdrawn: park with Y low.
            cnt   <= '0;
            run_q <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          run_q <= 1'b0;
          y_q   <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.Y   = y_q;
  assign bus.RUN = run_q;
  assign bus.ACK = ack_q;

endmodule
